axi_clint: RTL and testbench
============================

# axi_clint

Core-local interruptor that sits on the CPU peripheral AXI bus, directly feeding the core wrapper's `mtime`, `m_interrupt_timer` and `m_interrupt_software` inputs. It is an AXI4 slave with 32-bit data and 6-bit IDs that holds a free-running 64-bit `mtime` counter, a 64-bit `mtimecmp` compare register and an `msip` bit. From these it raises the machine timer and software interrupts. It supports single-beat and burst accesses, with independent read and write channels.

## Interface
- `TICK_DIV`, default 1: clock cycles per `mtime` increment, minimum 1.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `arvalid`, `araddr[31:0]`, `arlen[7:0]`, `arsize[2:0]`, `arburst[1:0]`, `arcache[3:0]`, `arid[5:0]`, `arlock`  in  read address channel.
- `arready`  out  1.
- `rvalid`, `rdata[31:0]`, `rresp[1:0]`, `rlast`, `rid[5:0]`  out  read data channel.
- `rready`  in  1.
- `awvalid`, `awaddr[31:0]`, `awlen[7:0]`, `awsize[2:0]`, `awburst[1:0]`, `awcache[3:0]`, `awid[5:0]`, `awlock`  in  write address channel.
- `awready`  out  1.
- `wvalid`, `wdata[31:0]`, `wstrb[3:0]`, `wlast`  in  write data channel.
- `wready`  out  1.
- `bvalid`, `bresp[1:0]`, `bid[5:0]`  out  write response channel.
- `bready`  in  1.
- `mtime`  out  64  current timer value.
- `m_interrupt_timer`  out  1  asserted while `mtime >= mtimecmp`.
- `m_interrupt_software`  out  1  equals `msip`.

## Operation
- Decode uses `addr[15:0]` only, as word offsets:
  - 0x0000: `msip`, bit 0 only, other bits read 0.
  - 0x4000 / 0x4004: `mtimecmp` low / high.
  - 0xBFF8 / 0xBFFC: `mtime` low / high.
- Unmapped offsets read 0 and ignore writes. `rresp` and `bresp` are always OKAY (2'b00).
- Writes honour `wstrb` per byte.
- `arsize`/`awsize` are assumed 3'b010. `cache`, `lock` and the low two address bits are ignored.
- Burst addressing:
  - FIXED: same word every beat.
  - INCR and WRAP: add 4 per beat, wrapping within the 16-bit offset (0xFFFC goes to 0x0000).
- Read FSM, states R_IDLE and R_DATA:
  - R_IDLE: `arready`=1. On the AR handshake, latch id, address, burst and beat count = `arlen`+1, then go to R_DATA.
  - R_DATA: `rvalid`=1, `rid` = latched id, `rdata` = register at the current address. `rlast`=1 when beats remaining = 1.
  - On each `rvalid && rready`, advance the address. After the last beat, return to R_IDLE.
- Write FSM, states W_IDLE, W_DATA and W_RESP:
  - W_IDLE: `awready`=1. On the AW handshake, latch id, address and burst, then go to W_DATA.
  - W_DATA: `wready`=1. Each W handshake updates the addressed register and advances the address. A beat with `wlast`=1 moves to W_RESP; beat count is not checked.
  - W_RESP: `bvalid`=1, `bid` = latched id. On `bready`, go to W_IDLE.
- Timer:
  - A prescaler counts 0..`TICK_DIV`-1. `mtime` increments by 1 with full 64-bit carry on the cycle the prescaler wraps; 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
  - A bus write to either `mtime` half in the same cycle as an increment wins, and that cycle's increment is dropped.
  - The `mtimecmp` halves are written independently.
- `m_interrupt_timer` is registered: `(mtime_next >= mtimecmp_next)`, unsigned 64-bit compare.
- Read and write channels run concurrently. A read in the same cycle as a write to the same register returns the pre-write value.

## Timing
- Reset values:
  - FSMs in R_IDLE / W_IDLE.
  - `mtime`=0, `mtimecmp`=0xFFFF_FFFF_FFFF_FFFF, `msip`=0, prescaler=0.
  - `m_interrupt_timer`=0, `m_interrupt_software`=0.
  - `rvalid`=`bvalid`=`wready`=0. `rdata`, `rid`, `bid`, `rlast`=0.
  - `arready` and `awready` are forced 0 while `rst`=1 and are 1 on the first cycle after release.
- Read latency: AR handshake at cycle N, first `rvalid` at N+1, then one beat per cycle while `rready`=1.
- Write latency: AW handshake at N, `wready` at N+1. `bvalid` appears the cycle after the `wlast` handshake.
- `rvalid`/`bvalid` stay asserted with stable payload until accepted.
- Register updates are visible on reads one cycle after the W handshake. `m_interrupt_timer` reflects a write one cycle after the W handshake.
- Reset asserted mid-burst aborts the transaction immediately. No response is issued.

## Structure
- Package `clint_pkg`: offset constants (`MSIP_OFF`, `MTIMECMP_LO_OFF`, `MTIMECMP_HI_OFF`, `MTIME_LO_OFF`, `MTIME_HI_OFF`), the FSM state enums and the `AXI_RESP_OKAY` constant.
- Sub-module `clint_timer`: holds the prescaler, `mtime`, `mtimecmp`, the compare logic and the write ports. The top level holds the AXI FSMs and the register mux.

## Test plan
- Reset, `TICK_DIV`=1, no bus traffic, 10 cycles → `mtime`=10, `m_interrupt_timer`=0.
- Write `mtimecmp` high=0, then low=20, single beats → `m_interrupt_timer` rises on the cycle `mtime` reaches 20. Then write high=1 → the interrupt drops one cycle after the handshake.
- INCR write burst, `awlen`=1, to 0xBFF8 with data 0xFFFF_FFFF, 0x0000_0000 → next increment gives `mtime`=0x1_0000_0000. `bid` equals `awid`=0x2A.
- Write 0x1 to 0x0000 with `wstrb`=4'b0001 → `m_interrupt_software`=1. Same write with `wstrb`=4'b0010 → no change.
- INCR read burst, `arlen`=3, from 0x4000 with `rready` toggling every other cycle → data is `mtimecmp` low, `mtimecmp` high, 0, 0; `rlast` only on beat 4; `rid` matches `arid`.
- Simultaneous AR and AW handshakes, plus `rst` pulsed mid-read-burst → both channels complete independently before the pulse; after the reset, `rvalid`=0, `arready`=1, `mtime` restarts from 0.

Source files
------------

// File: rtl/clint_pkg.sv
// Shared definitions for the core-local interruptor: register offsets, AXI
// constants, channel FSM states and small datapath helpers.
package clint_pkg;

  localparam logic [15:0] MSIP_OFF        = 16'h0000;
  localparam logic [15:0] MTIMECMP_LO_OFF = 16'h4000;
  localparam logic [15:0] MTIMECMP_HI_OFF = 16'h4004;
  localparam logic [15:0] MTIME_LO_OFF    = 16'hBFF8;
  localparam logic [15:0] MTIME_HI_OFF    = 16'hBFFC;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [1:0] BURST_FIXED   = 2'b00;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;

  // INCR and WRAP both step by one word and roll over inside the 16-bit window.
  function automatic logic [15:0] next_offset(input logic [15:0] off, input logic [1:0] burst);
    return (burst == BURST_FIXED) ? off : off + 16'd4;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_timer.sv
// Free-running mtime counter with prescaler, mtimecmp register and the
// registered machine timer interrupt.
module clint_timer
  import clint_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mtime_lo_we,
  input  logic        mtime_hi_we,
  input  logic        mtimecmp_lo_we,
  input  logic        mtimecmp_hi_we,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic [63:0] mtime,
  output logic [63:0] mtimecmp,
  output logic        timer_irq
);

  localparam logic [31:0] PRESC_MAX = 32'(TICK_DIV - 1);

  logic [31:0] presc;
  logic        tick;
  logic [63:0] mtime_next;
  logic [63:0] mtimecmp_next;

  assign tick = (presc == PRESC_MAX);

  // A bus write to either mtime half swallows that cycle's increment.
  always_comb begin
    mtime_next    = mtime;
    mtimecmp_next = mtimecmp;
    if (mtime_lo_we || mtime_hi_we) begin
      if (mtime_lo_we) mtime_next[31:0]  = merge_bytes(mtime[31:0], wdata, wstrb);
      if (mtime_hi_we) mtime_next[63:32] = merge_bytes(mtime[63:32], wdata, wstrb);
    end else if (tick) begin
      mtime_next = mtime + 64'd1;
    end
    if (mtimecmp_lo_we) mtimecmp_next[31:0]  = merge_bytes(mtimecmp[31:0], wdata, wstrb);
    if (mtimecmp_hi_we) mtimecmp_next[63:32] = merge_bytes(mtimecmp[63:32], wdata, wstrb);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc     <= '0;
      mtime     <= '0;
      mtimecmp  <= '1;
      timer_irq <= 1'b0;
    end else begin
      presc     <= tick ? '0 : presc + 32'd1;
      mtime     <= mtime_next;
      mtimecmp  <= mtimecmp_next;
      timer_irq <= (mtime_next >= mtimecmp_next);
    end
  end

endmodule

// File: rtl/axi_clint.sv
// AXI4 slave front end of the core-local interruptor: independent read and
// write channel FSMs, register decode, msip storage and the timer instance.
module axi_clint
  import clint_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arvalid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [3:0]  arcache,
  input  logic [5:0]  arid,
  input  logic        arlock,
  output logic        arready,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic [5:0]  rid,
  input  logic        rready,
  input  logic        awvalid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [3:0]  awcache,
  input  logic [5:0]  awid,
  input  logic        awlock,
  output logic        awready,
  input  logic        wvalid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  output logic        wready,
  output logic        bvalid,
  output logic [1:0]  bresp,
  output logic [5:0]  bid,
  input  logic        bready,
  output logic [63:0] mtime,
  output logic        m_interrupt_timer,
  output logic        m_interrupt_software
);

  r_state_t    r_state, r_state_next;
  w_state_t    w_state, w_state_next;
  logic [15:0] r_addr, w_addr;
  logic [1:0]  r_burst, w_burst;
  logic [8:0]  r_beats;
  logic        msip;
  logic [63:0] mtimecmp;
  logic        ar_hs, r_hs, aw_hs, w_hs;
  logic [15:0] ar_off, aw_off, r_next_off;
  logic        unused_bits;

  assign unused_bits = ^{araddr[31:16], araddr[1:0], arsize, arcache, arlock,
                         awaddr[31:16], awaddr[1:0], awsize, awcache, awlock, awlen};

  assign ar_off     = {araddr[15:2], 2'b00};
  assign aw_off     = {awaddr[15:2], 2'b00};
  assign r_next_off = next_offset(r_addr, r_burst);
  assign ar_hs      = arvalid && arready;
  assign r_hs       = rvalid && rready;
  assign aw_hs      = awvalid && awready;
  assign w_hs       = wvalid && wready;

  assign rresp                = AXI_RESP_OKAY;
  assign bresp                = AXI_RESP_OKAY;
  assign m_interrupt_software = msip;

  function automatic logic [31:0] read_reg(input logic [15:0] off, input logic msip_v,
                                           input logic [63:0] t, input logic [63:0] c);
    case (off)
      MSIP_OFF:        return {31'd0, msip_v};
      MTIMECMP_LO_OFF: return c[31:0];
      MTIMECMP_HI_OFF: return c[63:32];
      MTIME_LO_OFF:    return t[31:0];
      MTIME_HI_OFF:    return t[63:32];
      default:         return 32'd0;
    endcase
  endfunction

  always_comb begin
    r_state_next = r_state;
    arready      = 1'b0;
    rvalid       = 1'b0;
    rlast        = 1'b0;
    case (r_state)
      R_IDLE: begin
        arready = !rst;
        if (arvalid && !rst) r_state_next = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        rlast  = (r_beats == 9'd1);
        if (rready && rlast) r_state_next = R_IDLE;
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  // Read data is captured when a beat starts so it holds steady while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_addr  <= '0;
      r_burst <= '0;
      r_beats <= '0;
      rid     <= '0;
      rdata   <= '0;
    end else begin
      r_state <= r_state_next;
      if (ar_hs) begin
        r_addr  <= ar_off;
        r_burst <= arburst;
        r_beats <= {1'b0, arlen} + 9'd1;
        rid     <= arid;
        rdata   <= read_reg(ar_off, msip, mtime, mtimecmp);
      end else if (r_hs) begin
        r_addr  <= r_next_off;
        r_beats <= r_beats - 9'd1;
        rdata   <= rlast ? 32'd0 : read_reg(r_next_off, msip, mtime, mtimecmp);
      end
    end
  end

  always_comb begin
    w_state_next = w_state;
    awready      = 1'b0;
    wready       = 1'b0;
    bvalid       = 1'b0;
    case (w_state)
      W_IDLE: begin
        awready = !rst;
        if (awvalid && !rst) w_state_next = W_DATA;
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid && wlast) w_state_next = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      w_addr  <= '0;
      w_burst <= '0;
      bid     <= '0;
      msip    <= 1'b0;
    end else begin
      w_state <= w_state_next;
      if (aw_hs) begin
        w_addr  <= aw_off;
        w_burst <= awburst;
        bid     <= awid;
      end else if (w_hs) begin
        w_addr <= next_offset(w_addr, w_burst);
      end
      if (w_hs && (w_addr == MSIP_OFF) && wstrb[0]) msip <= wdata[0];
    end
  end

  clint_timer #(
    .TICK_DIV(TICK_DIV)
  ) u_timer (
    .clk            (clk),
    .rst            (rst),
    .mtime_lo_we    (w_hs && (w_addr == MTIME_LO_OFF)),
    .mtime_hi_we    (w_hs && (w_addr == MTIME_HI_OFF)),
    .mtimecmp_lo_we (w_hs && (w_addr == MTIMECMP_LO_OFF)),
    .mtimecmp_hi_we (w_hs && (w_addr == MTIMECMP_HI_OFF)),
    .wdata          (wdata),
    .wstrb          (wstrb),
    .mtime          (mtime),
    .mtimecmp       (mtimecmp),
    .timer_irq      (m_interrupt_timer)
  );

endmodule

// File: tb/tb_axi_clint.sv
// Directed scoreboard bench for axi_clint: read beats and write responses are
// checked by a monitor against queued expectations; sideband outputs directly.
module tb_axi_clint;

  logic        clk, rst;
  logic        arvalid, arready, arlock;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arcache;
  logic [5:0]  arid;
  logic        rvalid, rlast, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [5:0]  rid;
  logic        awvalid, awready, awlock;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [3:0]  awcache;
  logic [5:0]  awid;
  logic        wvalid, wlast, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic [5:0]  bid;
  logic [63:0] mtime;
  logic        m_interrupt_timer, m_interrupt_software;

  axi_clint #(.TICK_DIV(1)) dut (
    .clk(clk), .rst(rst),
    .arvalid(arvalid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arcache(arcache), .arid(arid), .arlock(arlock), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid), .rready(rready),
    .awvalid(awvalid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awcache(awcache), .awid(awid), .awlock(awlock), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bid(bid), .bready(bready),
    .mtime(mtime), .m_interrupt_timer(m_interrupt_timer),
    .m_interrupt_software(m_interrupt_software)
  );

  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct { string name; logic [31:0] data; logic [5:0] id; logic last; } rexp_t;
  typedef struct { string name; logic [5:0] id; } bexp_t;
  rexp_t rq[$];
  bexp_t bq[$];
  rexp_t re;
  bexp_t be;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string what);
    assertCount++;
    failCount++;
    $display("[TB] FAIL %s", what);
  endtask

  // Monitor: pops one expectation per accepted read beat or write response.
  always @(negedge clk) begin
    if (!rst) begin
      if (rvalid && rready) begin
        if (rq.size() == 0) failNow($sformatf("unexpected read beat: got rdata 0x%0h, expected none", rdata));
        else begin
          re = rq.pop_front();
          checkOutput({re.name, ".rdata"}, 64'(rdata), 64'(re.data));
          checkOutput({re.name, ".rid"},   64'(rid),   64'(re.id));
          checkOutput({re.name, ".rlast"}, 64'(rlast), 64'(re.last));
          checkOutput({re.name, ".rresp"}, 64'(rresp), 64'd0);
        end
      end
      if (bvalid && bready) begin
        if (bq.size() == 0) failNow($sformatf("unexpected write response: got bid 0x%0h, expected none", bid));
        else begin
          be = bq.pop_front();
          checkOutput({be.name, ".bid"},   64'(bid),   64'(be.id));
          checkOutput({be.name, ".bresp"}, 64'(bresp), 64'd0);
        end
      end
    end
  end

  function automatic logic readyOf(input int ch);
    case (ch)
      0:       return arready;
      1:       return awready;
      2:       return wready;
      3:       return bvalid;
      default: return 1'b0;
    endcase
  endfunction

  task automatic waitHs(input int ch, input string what);
    int n = 0;
    while (!readyOf(ch) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!readyOf(ch)) failNow($sformatf("%s handshake: got no ready in 50 cycles, expected ready", what));
    else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic expectRead(input string name, input logic [31:0] d, input logic [5:0] id, input logic last);
    rexp_t e;
    e.name = name; e.data = d; e.id = id; e.last = last;
    rq.push_back(e);
  endtask

  task automatic startWrite(input logic [31:0] addr, input logic [5:0] id, input logic [1:0] burst,
                            input int beats, input logic [31:0] d0, input logic [31:0] d1,
                            input logic [3:0] strb);
    bexp_t e;
    e.name = $sformatf("wr@%0h", addr); e.id = id;
    bq.push_back(e);
    awaddr = addr; awid = id; awburst = burst; awlen = 8'(beats - 1); awvalid = 1'b1;
    waitHs(1, "AW");
    awvalid = 1'b0;
    for (int i = 0; i < beats; i++) begin
      wdata = (i == 0) ? d0 : d1; wstrb = strb; wlast = (i == beats - 1); wvalid = 1'b1;
      waitHs(2, "W");
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic finishWrite();
    waitHs(3, "B");
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [5:0] id,
                               input logic [31:0] d, input logic [3:0] strb);
    startWrite(addr, id, INCR, 1, d, 32'd0, strb);
    finishWrite();
  endtask

  task automatic issueRead(input logic [31:0] addr, input logic [7:0] len, input logic [5:0] id,
                           input logic [1:0] burst, input bit toggle);
    int got = 0;
    int cyc = 0;
    int total = int'(len) + 1;
    araddr = addr; arlen = len; arid = id; arburst = burst; arvalid = 1'b1;
    waitHs(0, "AR");
    arvalid = 1'b0;
    while (got < total && cyc < 100) begin
      rready = toggle ? ((cyc % 2) == 0) : 1'b1;
      if (rvalid && rready) got++;
      @(posedge clk); #1; cyc++;
    end
    rready = 1'b0;
    if (got < total) failNow($sformatf("read id %0h: got %0d beats, expected %0d", id, got, total));
  endtask

  task automatic resetDut();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation still running at 300us, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1;
    arvalid = 0; araddr = 0; arlen = 0; arsize = 3'b010; arburst = INCR; arcache = 0; arid = 0; arlock = 0;
    awvalid = 0; awaddr = 0; awlen = 0; awsize = 3'b010; awburst = INCR; awcache = 0; awid = 0; awlock = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; rready = 0; bready = 1;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.arready", 64'(arready), 64'd0);
    checkOutput("reset.awready", 64'(awready), 64'd0);
    checkOutput("reset.rvalid",  64'(rvalid),  64'd0);
    checkOutput("reset.wready",  64'(wready),  64'd0);
    checkOutput("reset.bvalid",  64'(bvalid),  64'd0);
    checkOutput("reset.mtime",   mtime,        64'd0);
    checkOutput("reset.mti",     64'(m_interrupt_timer),    64'd0);
    checkOutput("reset.msi",     64'(m_interrupt_software), 64'd0);
    rst = 1'b0;
    #1;
    checkOutput("release.arready", 64'(arready), 64'd1);
    checkOutput("release.awready", 64'(awready), 64'd1);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("idle10.mtime", mtime, 64'd10);
    checkOutput("idle10.mti",   64'(m_interrupt_timer), 64'd0);

    $display("[TB] timer compare");
    resetDut();
    applyStimulus(32'h4004, 6'h01, 32'd0,  4'hF);
    applyStimulus(32'h4000, 6'h02, 32'd20, 4'hF);
    n = 0;
    while (mtime != 64'd19 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    checkOutput("cmp.mti_at_19", 64'(m_interrupt_timer), 64'd0);
    @(posedge clk); #1;
    checkOutput("cmp.mtime_20", mtime, 64'd20);
    checkOutput("cmp.mti_at_20", 64'(m_interrupt_timer), 64'd1);
    startWrite(32'h4004, 6'h03, INCR, 1, 32'd1, 32'd0, 4'hF);
    checkOutput("cmp.mti_drop", 64'(m_interrupt_timer), 64'd0);
    finishWrite();

    $display("[TB] mtime burst write");
    startWrite(32'hBFF8, 6'h2A, INCR, 2, 32'hFFFF_FFFF, 32'h0000_0000, 4'hF);
    checkOutput("mtime.written", mtime, 64'h0000_0000_FFFF_FFFF);
    finishWrite();
    checkOutput("mtime.carry", mtime, 64'h0000_0001_0000_0000);

    $display("[TB] msip strobes");
    applyStimulus(32'h0000, 6'h04, 32'h1, 4'b0010);
    checkOutput("msip.strb_hi_from0", 64'(m_interrupt_software), 64'd0);
    applyStimulus(32'h0000, 6'h05, 32'h1, 4'b0001);
    checkOutput("msip.set", 64'(m_interrupt_software), 64'd1);
    applyStimulus(32'h0000, 6'h06, 32'h0, 4'b0010);
    checkOutput("msip.strb_hi_from1", 64'(m_interrupt_software), 64'd1);
    applyStimulus(32'h0000, 6'h07, 32'hFFFF_FFFF, 4'hF);
    expectRead("msip.read", 32'h1, 6'h0B, 1'b1);
    issueRead(32'h0000, 8'd0, 6'h0B, INCR, 1'b0);

    $display("[TB] read bursts");
    expectRead("rb.cmp_lo", 32'd20, 6'h15, 1'b0);
    expectRead("rb.cmp_hi", 32'd1,  6'h15, 1'b0);
    expectRead("rb.unmap0", 32'd0,  6'h15, 1'b0);
    expectRead("rb.unmap1", 32'd0,  6'h15, 1'b1);
    issueRead(32'h0000_4000, 8'd3, 6'h15, INCR, 1'b1);
    expectRead("wrap.fffc", 32'd0, 6'h16, 1'b0);
    expectRead("wrap.0000", 32'd1, 6'h16, 1'b1);
    issueRead(32'h1234_FFFC, 8'd1, 6'h16, INCR, 1'b0);
    expectRead("fixed.b0", 32'd20, 6'h17, 1'b0);
    expectRead("fixed.b1", 32'd20, 6'h17, 1'b1);
    issueRead(32'h0000_4000, 8'd1, 6'h17, FIXED, 1'b0);

    $display("[TB] concurrent channels");
    expectRead("conc.rd", 32'd20, 6'h08, 1'b1);
    fork
      issueRead(32'h4000, 8'd0, 6'h08, INCR, 1'b0);
      applyStimulus(32'h4004, 6'h31, 32'd2, 4'hF);
    join
    expectRead("conc.hi", 32'd2, 6'h09, 1'b1);
    issueRead(32'h4004, 8'd0, 6'h09, INCR, 1'b0);

    $display("[TB] reset mid burst");
    expectRead("abort.b0", 32'd20, 6'h0A, 1'b0);
    araddr = 32'h4000; arlen = 8'd7; arid = 6'h0A; arburst = INCR; arvalid = 1'b1;
    waitHs(0, "AR");
    arvalid = 1'b0;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    checkOutput("abort.stall_rdata", 64'(rdata), 64'd2);
    @(posedge clk); #1;
    checkOutput("abort.hold_rdata", 64'(rdata), 64'd2);
    checkOutput("abort.hold_rvalid", 64'(rvalid), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort.arready_in_rst", 64'(arready), 64'd0);
    rst = 1'b0;
    #1;
    checkOutput("abort.rvalid", 64'(rvalid), 64'd0);
    checkOutput("abort.arready", 64'(arready), 64'd1);
    checkOutput("abort.mtime0", mtime, 64'd0);
    @(posedge clk); #1;
    checkOutput("abort.mtime1", mtime, 64'd1);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("end.read_queue", 64'(rq.size()), 64'd0);
    checkOutput("end.resp_queue", 64'(bq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
